rr_mux_4_1: RTL and testbench
=============================

# rr_mux_4_1

Four-channel round-robin multiplexer with a valid/ready handshake. It merges four producer streams onto one shared output and tags every word with the index of its source channel. It is the transmit end of the 1:4 demultiplexer path: `Select_Out` drives the downstream DEMUX select and `Data_Out` drives its data input. One output register stage decouples arbitration from the consumer.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of each channel's data word.

Ports (one clock; reset is asynchronous and active-low):
- `Clock_In`  in  1  sole clock; all state updates on its rising edge.
- `Reset_N_In`  in  1  asynchronous, active-low reset.
- `Enable_In`  in  1  when low, no new word is granted; a word already held still drains.
- `Data_0_In` .. `Data_3_In`  in  DATA_WIDTH each  per-channel data.
- `Valid_In`  in  4  bit i high means channel i holds a word.
- `Ready_Out`  out  4  bit i high means channel i's word is accepted this cycle.
- `Data_Out`  out  DATA_WIDTH  registered output word.
- `Select_Out`  out  2  source channel index of `Data_Out`.
- `Valid_Out`  out  1  output register holds a word.
- `Ready_In`  in  1  downstream accepts `Data_Out` this cycle.

## Operation
- Two-state FSM with states EMPTY and FULL.
  - Internal `load = (state==EMPTY) || Ready_In`.
  - Grant: `Ready_Out[g]` is high only when `Enable_In && load && Valid_In[g]` and g is the arbiter winner. At most one bit of `Ready_Out` is high.
- Round-robin arbitration:
  - The search starts at `(last_grant+1) mod 4` and wraps past channel 3 to channel 0.
  - The first channel found with `Valid_In` high wins.
  - `last_grant` updates only on an actual transfer into the register.
- On a grant:
  - `Data_Out` loads the winner's data and `Select_Out` loads g.
  - The state becomes FULL.
- In FULL with `Ready_In` high and no grant:
  - The state becomes EMPTY and `Valid_Out` drops.
  - `Data_Out` and `Select_Out` hold their last values.
- In FULL with `Ready_In` high and a grant: back-to-back transfer; the state stays FULL.
- In FULL with `Ready_In` low: all outputs hold and `Ready_Out` is 0.
- `Ready_Out` and `load` are combinational from `Valid_In`, `Ready_In`, `Enable_In` and state. No output depends combinationally on `Data_*_In`.
- `Valid_Out` is equivalent to `state==FULL`.

## Timing
- Reset values:
  - `Data_Out` = 0, `Select_Out` = 0, `Valid_Out` = 0.
  - State = EMPTY; `last_grant` = 3, so channel 0 has first priority.
- During reset, `Ready_Out` = 0.
- Reset asserted mid-transfer discards the held word immediately. The consumer must not sample while `Reset_N_In` is low.
- Latency: an input accepted in cycle N appears with `Valid_Out` high in cycle N+1.
- Throughput: one word per cycle while `Ready_In` stays high.
- Fairness: when all four channels are continuously valid, the grant order is 0,1,2,3,0,… and any channel waits at most 3 grants.
- An input word is held stable by its producer until its `Ready_Out` bit is high. A `Valid_In` bit dropping without a grant is legal and is simply skipped.
- When `Enable_In` falls, it blocks grants in the same cycle and does not affect the draining of a held word.

## Configuration
- Macro `RR_MUX_FIXED_PRIORITY_EN`.
  - Defined: the arbiter uses fixed priority (channel 0 highest, channel 3 lowest), and `last_grant` is not implemented.
  - Undefined (default): round-robin as specified above.
- All handshake, latency and reset behaviour is identical in both builds.

## Structure
- Package `rr_mux_pkg` holds:
  - `NUM_CH` = 4 and `SEL_WIDTH` = 2.
  - The state enum `rr_mux_state_t` {EMPTY, FULL}.
- Sub-module `rr_arbiter_4`:
  - Combinational grant logic.
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant, encoded index and any-grant.
  - The macro selection lives inside this sub-module.
- The top level holds the FSM, the output register and the `last_grant` register.

## Test plan
- Reset: assert `Reset_N_In`=0 with all `Valid_In`=1 → all outputs 0 and `Ready_Out`=0. Release → first grant goes to channel 0, with `Select_Out`=0 one cycle later.
- Round-robin: all valid, `Ready_In`=1, channel i data = 8'hA0+i → `Select_Out` cycles 0,1,2,3,0 and `Data_Out` = A0,A1,A2,A3,A0 on consecutive cycles.
- Backpressure: hold `Ready_In`=0 for 5 cycles while FULL → `Data_Out`, `Select_Out` and `Valid_Out` are unchanged and `Ready_Out`=0. Raise `Ready_In` → the next word loads the same cycle.
- Sparse and wrap: only channels 1 and 3 valid, with `last_grant`=3 → grants go 1,3,1,3. Channel 0 asserted after a grant to 3 → the next grant is 0.
- Enable: set `Enable_In`=0 while FULL and `Ready_In`=1 → the held word drains, `Valid_Out` goes 0 and no new grant occurs until `Enable_In`=1.
- Fixed-priority build (`RR_MUX_FIXED_PRIORITY_EN` defined), all valid → `Select_Out` stays 0 every cycle.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants and state type for the 4:1 round-robin mux.
// Build option: RR_MUX_FIXED_PRIORITY_EN selects fixed-priority arbitration.
package rr_mux_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_WIDTH = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rr_mux_state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way arbiter: round-robin by default.
// RR_MUX_FIXED_PRIORITY_EN: fixed priority, channel 0 highest.
module rr_arbiter_4
  import rr_mux_pkg::*;
(
  input  logic [NUM_CH-1:0]    req_i,
`ifndef RR_MUX_FIXED_PRIORITY_EN
  input  logic [SEL_WIDTH-1:0] last_grant_i,
`endif
  output logic [NUM_CH-1:0]    gnt_o,
  output logic [SEL_WIDTH-1:0] idx_o,
  output logic                 any_o
);

`ifdef RR_MUX_FIXED_PRIORITY_EN
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    // Scan high to low so the lowest requester wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        idx_o = SEL_WIDTH'(k);
        any_o = 1'b1;
      end
    end
  end
`else
  logic [SEL_WIDTH-1:0] cand;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    // Search starts one past the last winner and wraps.
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last_grant_i + SEL_WIDTH'(k);
      if (!any_o && req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end
`endif

  assign gnt_o = any_o ? (NUM_CH'(1) << idx_o) : '0;

endmodule

// File: rtl/rr_mux_4_1.sv
// 4:1 round-robin mux with one registered output stage.
// Build option: RR_MUX_FIXED_PRIORITY_EN (fixed-priority arbiter).
module rr_mux_4_1
  import rr_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_N_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_0_In,
  input  logic [DATA_WIDTH-1:0] Data_1_In,
  input  logic [DATA_WIDTH-1:0] Data_2_In,
  input  logic [DATA_WIDTH-1:0] Data_3_In,
  input  logic [NUM_CH-1:0]     Valid_In,
  output logic [NUM_CH-1:0]     Ready_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic [SEL_WIDTH-1:0]  Select_Out,
  output logic                  Valid_Out,
  input  logic                  Ready_In
);

  rr_mux_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  load;
  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     gnt;
  logic [SEL_WIDTH-1:0]  idx;
  logic                  any;

  assign load = (state_q == EMPTY) || Ready_In;
  // Reset term keeps Ready_Out low while reset is held.
  assign req  = Valid_In & {NUM_CH{Enable_In & load & Reset_N_In}};

`ifndef RR_MUX_FIXED_PRIORITY_EN
  logic [SEL_WIDTH-1:0] last_q;

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      last_q <= SEL_WIDTH'(NUM_CH - 1);
    end else if (any) begin
      last_q <= idx;
    end
  end
`endif

  rr_arbiter_4 u_arb (
    .req_i        (req),
`ifndef RR_MUX_FIXED_PRIORITY_EN
    .last_grant_i (last_q),
`endif
    .gnt_o        (gnt),
    .idx_o        (idx),
    .any_o        (any)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (any) begin
      state_d = FULL;
      sel_d   = idx;
      unique case (idx)
        2'd0: data_d = Data_0_In;
        2'd1: data_d = Data_1_In;
        2'd2: data_d = Data_2_In;
        2'd3: data_d = Data_3_In;
      endcase
    end else if (Ready_In) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign Ready_Out  = gnt;
  assign Data_Out   = data_q;
  assign Select_Out = sel_q;
  assign Valid_Out  = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux_4_1.sv
// Bench for rr_mux_4_1: directed literal checks plus a randomized run
// compared every cycle against a behavioural model.
module tb_rr_mux_4_1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] d [4];
  logic [3:0] vin;
  logic [3:0] rdy_out;
  logic [7:0] dout;
  logic [1:0] sel;
  logic       vout;
  logic       rdy;

  int checks = 0;
  int errors = 0;

  rr_mux_4_1 #(.DATA_WIDTH(8)) dut (
    .Clock_In   (clk),
    .Reset_N_In (rst_n),
    .Enable_In  (en),
    .Data_0_In  (d[0]),
    .Data_1_In  (d[1]),
    .Data_2_In  (d[2]),
    .Data_3_In  (d[3]),
    .Valid_In   (vin),
    .Ready_Out  (rdy_out),
    .Data_Out   (dout),
    .Select_Out (sel),
    .Valid_Out  (vout),
    .Ready_In   (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner: first valid channel at or after (last+1) mod 4, or -1.
  function automatic int pick(logic [3:0] v, int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Behavioural model of the output register and handshake.
  logic       m_full;
  logic [7:0] m_data;
  logic [1:0] m_sel;
  int         m_last;

  always @(negedge clk) begin
    int         w;
    logic [3:0] eg;
    eg = 4'b0;
    w  = -1;
    if (!rst_n) begin
      m_full = 1'b0;
      m_data = 8'h00;
      m_sel  = 2'd0;
      m_last = 3;
    end else if (en && (!m_full || rdy)) begin
      w = pick(vin, m_last);
      if (w >= 0) eg = 4'b1 << w;
    end
    checks++;
    if (rdy_out !== eg || vout !== m_full ||
        dout !== m_data || sel !== m_sel) begin
      errors++;
      $display("FAIL model_cmp t=%0t ready_out=%b exp=%b valid=%b exp=%b data=%h exp=%h sel=%0d exp=%0d",
               $time, rdy_out, eg, vout, m_full, dout, m_data, sel, m_sel);
    end
    if (rst_n) begin
      if (w >= 0) begin
        m_full = 1'b1;
        m_data = d[w];
        m_sel  = 2'(w);
`ifndef RR_MUX_FIXED_PRIORITY_EN
        m_last = w;
`endif
      end else if (rdy) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         rr_seq [6];
  logic [3:0] g;

  initial begin
`ifdef RR_MUX_FIXED_PRIORITY_EN
    rr_seq = '{0, 0, 0, 0, 0, 0};
`else
    rr_seq = '{0, 1, 2, 3, 0, 1};
`endif
    rst_n = 1'b0;
    en    = 1'b1;
    rdy   = 1'b1;
    vin   = 4'hF;
    for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);

    // Reset with everything valid.
    repeat (2) @(negedge clk);
    chk("rst_ready_out", 32'(rdy_out), 32'h0);
    chk("rst_valid_out", 32'(vout), 32'h0);
    chk("rst_data_out", 32'(dout), 32'h0);
    chk("rst_sel_out", 32'(sel), 32'h0);

    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(rdy_out), 32'h1);

    // All valid, consumer always ready.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_sel", 32'(sel), 32'(rr_seq[k]));
      chk("rr_data", 32'(dout), 32'h0A0 + 32'(rr_seq[k]));
      chk("rr_valid", 32'(vout), 32'h1);
    end

    // Backpressure: hold for 5 cycles.
    step();
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
`ifdef RR_MUX_FIXED_PRIORITY_EN
      chk("bp_sel", 32'(sel), 32'h0);
      chk("bp_data", 32'(dout), 32'hA0);
`else
      chk("bp_sel", 32'(sel), 32'h2);
      chk("bp_data", 32'(dout), 32'hA2);
`endif
      chk("bp_valid", 32'(vout), 32'h1);
      chk("bp_ready_out", 32'(rdy_out), 32'h0);
    end
    step();
    rdy = 1'b1;
    @(negedge clk);
`ifdef RR_MUX_FIXED_PRIORITY_EN
    chk("bp_release", 32'(rdy_out), 32'h1);
`else
    chk("bp_release", 32'(rdy_out), 32'h8);
`endif

    // Sparse: channels 1 and 3 only, then add channel 0.
    step();
    vin = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef RR_MUX_FIXED_PRIORITY_EN
      chk("sparse_gnt", 32'(rdy_out), 32'h2);
`else
      chk("sparse_gnt", 32'(rdy_out), (k % 2 == 0) ? 32'h2 : 32'h8);
`endif
      if (k < 3) step();
    end
    step();
    vin = 4'b1011;
    @(negedge clk);
    chk("wrap_to_0", 32'(rdy_out), 32'h1);

    // Enable low drains the held word with no new grant.
    step();
    en  = 1'b0;
    vin = 4'hF;
    @(negedge clk);
    chk("en_off_gnt", 32'(rdy_out), 32'h0);
    chk("en_off_held", 32'(vout), 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("en_off_drained", 32'(vout), 32'h0);
      chk("en_off_gnt2", 32'(rdy_out), 32'h0);
    end
    step();
    en = 1'b1;
    @(negedge clk);
`ifdef RR_MUX_FIXED_PRIORITY_EN
    chk("en_on_gnt", 32'(rdy_out), 32'h1);
`else
    chk("en_on_gnt", 32'(rdy_out), 32'h2);
`endif

    // Random traffic; producers hold words until granted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      g = rdy_out;
      step();
      for (int c = 0; c < 4; c++) begin
        if (!vin[c] || g[c]) begin
          vin[c] = ($urandom_range(0, 2) != 0);
          d[c]   = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          vin[c] = 1'b0;
        end
      end
      rdy   = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end

    step();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
